// File: rtl/regfile_wb_sched.sv
// Register-file write-port arbiter: pipeline writeback has priority over
// round-robin long-latency units; also keeps a scoreboard of pending writes.
module regfile_wb_sched #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned NL         = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               P_VALID,
  input  logic [4:0]         P_RD,
  input  logic [XLEN-1:0]    P_WD,
  input  logic [NL-1:0]      L_VALID,
  input  logic [5*NL-1:0]    L_RD,
  input  logic [XLEN*NL-1:0] L_WD,
  output logic [NL-1:0]      L_READY,
  input  logic               ISS_VALID,
  input  logic [4:0]         ISS_RD,
  input  logic [4:0]         Q1,
  input  logic [4:0]         Q2,
  output logic               BUSY1,
  output logic               BUSY2,
  output logic               STALL_REQ,
  output logic               WE3,
  output logic [4:0]         A3,
  output logic [XLEN-1:0]    WD3
);

  localparam int unsigned RRW = (NL > 1) ? $clog2(NL) : 1;
  localparam int unsigned CW  = 4;

  logic [RRW-1:0]  rr_q, rr_d;
  logic [CW-1:0]   wait_q, wait_d;
  logic            stall_q, stall_d;
  logic [31:0]     busy_q, busy_d;

  logic            p_live;
  logic            found;
  logic            xfer;
  logic [NL-1:0]   grant;
  logic [4:0]      g_rd;
  logic [XLEN-1:0] g_wd;

  // First valid unit at or after the round-robin pointer.
  always_comb begin : arb
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < int'(NL); k++) begin
      for (int i = 0; i < int'(NL); i++) begin
        if (!found && L_VALID[i] && (((32'(rr_q) + 32'(k)) % NL) == 32'(i))) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

  always_comb begin : sel
    g_rd = '0;
    g_wd = '0;
    for (int i = 0; i < int'(NL); i++) begin
      if (grant[i]) begin
        g_rd = L_RD[5*i +: 5];
        g_wd = L_WD[XLEN*i +: XLEN];
      end
    end
  end

  assign p_live = P_VALID && (P_RD != 5'd0);
  // A rd=0 grant still consumes the transfer; it just does not write.
  assign xfer   = RST_N && !p_live && found;

  always_comb begin : wport
    L_READY = '0;
    WE3     = 1'b0;
    A3      = '0;
    WD3     = '0;
    if (RST_N) begin
      if (p_live) begin
        WE3 = 1'b1;
        A3  = P_RD;
        WD3 = P_WD;
      end else if (xfer) begin
        L_READY = grant;
        WE3     = (g_rd != 5'd0);
        A3      = g_rd;
        WD3     = g_wd;
      end
    end
  end

  always_comb begin : nxt
    rr_d = rr_q;
    for (int i = 0; i < int'(NL); i++) begin
      if (xfer && grant[i]) rr_d = RRW'((i + 1) % int'(NL));
    end

    if (xfer || !(|L_VALID)) begin
      wait_d = '0;
    end else if (wait_q != '1) begin
      wait_d = wait_q + CW'(1);
    end else begin
      wait_d = wait_q;
    end
    stall_d = (32'(wait_d) >= STARVE_MAX);

    // Issue is applied after the clear so a same-register issue wins.
    busy_d = busy_q;
    if (xfer && (g_rd != 5'd0)) busy_d[g_rd] = 1'b0;
    if (ISS_VALID && (ISS_RD != 5'd0)) busy_d[ISS_RD] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rr_q    <= '0;
      wait_q  <= '0;
      stall_q <= 1'b0;
      busy_q  <= '0;
    end else begin
      rr_q    <= rr_d;
      wait_q  <= wait_d;
      stall_q <= stall_d;
      busy_q  <= busy_d;
    end
  end

  assign STALL_REQ = stall_q;
  assign BUSY1     = busy_q[Q1];
  assign BUSY2     = busy_q[Q2];

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Randomized and directed check of regfile_wb_sched against a
// behavioural model of arbitration, starvation and the scoreboard.
module tb_regfile_wb_sched;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NL   = 2;
  localparam int unsigned SMAX = 4;

  logic              clk;
  logic              rst_n;
  logic              pv;
  logic [4:0]        prd;
  logic [XLEN-1:0]   pwd;
  logic [NL-1:0]     lv;
  logic [5*NL-1:0]   lrd;
  logic [XLEN*NL-1:0] lwd;
  logic [NL-1:0]     lready;
  logic              iv;
  logic [4:0]        ird;
  logic [4:0]        q1, q2;
  logic              busy1, busy2, stall;
  logic              we3;
  logic [4:0]        a3;
  logic [XLEN-1:0]   wd3;

  regfile_wb_sched #(.XLEN(XLEN), .NL(NL), .STARVE_MAX(SMAX)) dut (
    .CLK(clk), .RST_N(rst_n),
    .P_VALID(pv), .P_RD(prd), .P_WD(pwd),
    .L_VALID(lv), .L_RD(lrd), .L_WD(lwd), .L_READY(lready),
    .ISS_VALID(iv), .ISS_RD(ird),
    .Q1(q1), .Q2(q2), .BUSY1(busy1), .BUSY2(busy2),
    .STALL_REQ(stall), .WE3(we3), .A3(a3), .WD3(wd3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model state.
  bit [31:0] m_busy;
  int        m_rr;
  int        m_wait;
  bit        m_stall;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy  = '0;
    m_rr    = 0;
    m_wait  = 0;
    m_stall = 0;
  endtask

  function automatic logic [4:0] unit_rd(input int u);
    logic [5*NL-1:0] v;
    v = lrd;
    return v[5*u +: 5];
  endfunction

  function automatic logic [XLEN-1:0] unit_wd(input int u);
    logic [XLEN*NL-1:0] v;
    v = lwd;
    return v[XLEN*u +: XLEN];
  endfunction

  // One clock: compare mid-cycle, then advance the model at the edge.
  task automatic step(input string tag);
    bit        live;
    int        g;
    bit        xf;
    logic [4:0] grd;
    @(negedge clk);
    live = pv && (prd != 0);
    g = -1;
    if (!live) begin
      for (int k = 0; k < int'(NL); k++) begin
        int u;
        u = (m_rr + k) % int'(NL);
        if (g < 0 && lv[u]) g = u;
      end
    end
    xf  = (g >= 0);
    grd = xf ? unit_rd(g) : 5'd0;
    if (live) begin
      check_eq({tag, ".we"}, 64'(we3), 64'(1));
      check_eq({tag, ".a3"}, 64'(a3), 64'(prd));
      check_eq({tag, ".wd"}, 64'(wd3), 64'(pwd));
      check_eq({tag, ".rdy"}, 64'(lready), 64'(0));
    end else if (xf) begin
      check_eq({tag, ".rdy"}, 64'(lready), 64'(1) << g);
      check_eq({tag, ".we"}, 64'(we3), 64'(grd != 0));
      if (grd != 0) begin
        check_eq({tag, ".a3"}, 64'(a3), 64'(grd));
        check_eq({tag, ".wd"}, 64'(wd3), 64'(unit_wd(g)));
      end
    end else begin
      check_eq({tag, ".we"}, 64'(we3), 64'(0));
      check_eq({tag, ".a3"}, 64'(a3), 64'(0));
      check_eq({tag, ".wd"}, 64'(wd3), 64'(0));
      check_eq({tag, ".rdy"}, 64'(lready), 64'(0));
    end
    check_eq({tag, ".stall"}, 64'(stall), 64'(m_stall));
    check_eq({tag, ".busy1"}, 64'(busy1), 64'(m_busy[q1]));
    check_eq({tag, ".busy2"}, 64'(busy2), 64'(m_busy[q2]));
    @(posedge clk);
    if (xf) begin
      m_rr   = (g + 1) % int'(NL);
      m_wait = 0;
    end else if (lv != 0) begin
      m_wait = (m_wait < 15) ? m_wait + 1 : 15;
    end else begin
      m_wait = 0;
    end
    m_stall = (m_wait >= int'(SMAX));
    if (xf && grd != 0) m_busy[grd] = 1'b0;
    if (iv && ird != 0) m_busy[ird] = 1'b1;
    m_busy[0] = 1'b0;
    #1;
  endtask

  task automatic idle_inputs();
    pv = 0; prd = 0; pwd = 0; lv = 0; lrd = 0; lwd = 0;
    iv = 0; ird = 0; q1 = 0; q2 = 0;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    q1 = 5; q2 = 6;
    lv = 2'b11; lrd = {5'd4, 5'd2};
    #12;
    check_eq("rst.we", 64'(we3), 64'(0));
    check_eq("rst.rdy", 64'(lready), 64'(0));
    check_eq("rst.stall", 64'(stall), 64'(0));
    check_eq("rst.busy1", 64'(busy1), 64'(0));
    lv = 0; lrd = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    step("idle0");
    step("idle1");

    // Pipeline beats unit 0, then unit 0 drains.
    pv = 1; prd = 3; pwd = 32'hA5A5A5A5;
    lv = 2'b01; lrd = {5'd0, 5'd7}; lwd = {32'h0, 32'h1234_5678};
    step("pvl0");
    pv = 0;
    step("l0go");
    lv = 0;
    step("l0idle");

    // Round-robin alternation; P_RD=0 slot does not block.
    lv = 2'b11; lrd = {5'd4, 5'd2}; lwd = {32'hBBBB_0001, 32'hAAAA_0000};
    step("rr0");
    pv = 1; prd = 0; pwd = 32'hDEAD_BEEF;
    step("rr1");
    pv = 0;
    step("rr2");
    step("rr3");
    lv = 0;
    step("rrend");

    // Starvation.
    pv = 1; prd = 9; pwd = 32'h0000_0099;
    lv = 2'b01; lrd = {5'd0, 5'd11};
    for (int c = 0; c < 6; c++) step("starve");
    pv = 0;
    step("unstarve");
    lv = 0;
    step("stallclr");

    // Scoreboard set/clear ordering.
    iv = 1; ird = 12; q1 = 12; q2 = 0;
    step("iss12");
    iv = 0;
    step("busy12");
    iv = 1; ird = 12; lv = 2'b10; lrd = {5'd12, 5'd0}; lwd = {32'hC0DE_0012, 32'h0};
    step("setwins");
    iv = 0; lv = 0;
    step("still12");
    lv = 2'b10;
    step("clr12");
    lv = 0;
    step("free12");
    iv = 1; ird = 0;
    step("iss0");
    iv = 0;
    step("q0");

    // Randomized traffic over a small register range.
    for (int c = 0; c < 400; c++) begin
      pv  = ($urandom_range(0, 9) < 6);
      prd = 5'($urandom_range(0, 7));
      pwd = $urandom;
      lv  = NL'($urandom);
      lrd = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      lwd = {$urandom, $urandom};
      iv  = ($urandom_range(0, 2) == 0);
      ird = 5'($urandom_range(0, 7));
      q1  = 5'($urandom_range(0, 7));
      q2  = 5'($urandom_range(0, 7));
      step("rand");
    end

    // Asynchronous reset mid-operation.
    idle_inputs();
    iv = 1; ird = 12;
    step("pre.iss");
    iv = 0;
    pv = 1; prd = 9; lv = 2'b10; lrd = {5'd12, 5'd0}; q1 = 12;
    for (int c = 0; c < 5; c++) step("pre.starve");
    check_eq("pre.stall", 64'(stall), 64'(1));
    check_eq("pre.busy1", 64'(busy1), 64'(1));
    pv = 0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("arst.we", 64'(we3), 64'(0));
    check_eq("arst.rdy", 64'(lready), 64'(0));
    check_eq("arst.stall", 64'(stall), 64'(0));
    check_eq("arst.busy1", 64'(busy1), 64'(0));
    check_eq("arst.a3", 64'(a3), 64'(0));
    check_eq("arst.wd", 64'(wd3), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    step("post0");
    lv = 0;
    step("post1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
